fp_result_packer: RTL and testbench
===================================

// Module: fp_result_packer
// PURPOSE
//  Final pack stage of the FP datapath (multiplier, later adder/divider), parametrised in exponent/mantissa width.
//  Takes the normalised/rounded result plus special-case flags, forces special encodings and computes IEEE exception flags.
//  Delivers the packed result through a valid/ready output with a 2-entry skid buffer, so downstream back-pressure never drops data.
// PARAMETERS
//  EXP_W   8    exponent width (8 = single, 11 = double)
//  MAN_W   23   stored fraction width; the input mantissa carries MAN_W+1 bits (hidden bit at MSB)
// PORTS
//  CLK            in   1          clock, all logic on rising edge
//  RST            in   1          synchronous, active-high reset
//  in_valid       in   1          input result valid
//  in_ready       out  1          stage can accept input this cycle
//  in_sign        in   1          result sign
//  in_man         in   MAN_W+1    rounded mantissa, hidden bit at [MAN_W]
//  in_exp         in   EXP_W      biased exponent
//  in_zero        in   1          operand-derived exact zero
//  in_ovf         in   1          overflow detected upstream
//  in_unf         in   1          underflow/denormal case upstream
//  in_inv         in   1          invalid operation (NaN result)
//  in_inx         in   1          inexact (rounding discarded bits)
//  out_valid      out  1          packed result valid
//  out_ready      in   1          downstream accepts
//  out_sign       out  1          packed sign
//  out_exp        out  EXP_W      packed exponent
//  out_frac       out  MAN_W      packed fraction (hidden bit dropped)
//  out_flags      out  5          {inv, zero, ovf, unf, inx} for this result
//  flag_clr       in   1          clear sticky status (FPU_STICKY_FLAGS_EN only)
//  sticky_flags   out  5          accumulated {inv, zero, ovf, unf, inx}
// BEHAVIOUR
//  Special-case priority (combinational, per accepted input):
//   in_inv -> exp = all ones, frac = all ones (canonical NaN), sign passed through
//   else in_ovf -> exp = all ones, frac = 0 (signed infinity)
//   else in_unf -> exp = 0, frac = in_man[MAN_W-1:0] (denormal)
//   else -> exp = in_exp, frac = in_man[MAN_W-1:0]
//  Flags: inv = in_inv; ovf = in_ovf & ~in_inv; zero = in_zero | (exp==0 & frac==0), forced 0 when inv|ovf;
//   unf = in_unf & ~zero & ~inv & ~ovf; inx = in_inx | ovf (overflow is always inexact).
//  Pipeline: input accepted when in_valid & in_ready; packed word enters the output register (OR) if OR is empty or drains
//   the same cycle, else the skid register (SK). Latency 1 cycle (accept at N -> out_valid at N+1) with out_ready high.
//  Buffer states: EMPTY (OR, SK empty), ONE (OR full), FULL (OR and SK full).
//   EMPTY: push -> ONE.  ONE: push & ~pop -> FULL; pop & ~push -> EMPTY; push & pop -> ONE (new word in OR).
//   FULL: pop -> ONE (SK moves to OR); push is impossible since in_ready = 0.
//  in_ready is registered: 1 exactly when SK is empty; no combinational path from out_ready to in_ready.
//  out_valid = OR full; out_* held stable while out_valid & ~out_ready. Results leave in acceptance order.
//  Reset: out_valid=0, in_ready=1, out_sign/out_exp/out_frac/out_flags=0, sticky_flags=0, both entries empty.
//  RST asserted mid-transfer discards buffered results; no partial word is ever presented.
// CONFIGURATION
//  FPU_STICKY_FLAGS_EN defined: sticky_flags |= out_flags on each output handshake (out_valid & out_ready).
//   flag_clr zeroes the accumulated value; a handshake in the same cycle ORs its flags into the cleared value (never lost).
//  Not defined: sticky_flags tied to 0, flag_clr ignored, no sticky register synthesised.
// TESTING
//  Defaults, in_man=24'h800000, in_exp=8'h7F, sign=0, out_ready=1 -> next cycle exp=8'h7F, frac=0, flags=5'b00000.
//  in_ovf=1, in_inv=1, sign=1 -> exp=8'hFF, frac=23'h7FFFFF, flags inv=1, ovf=0, inx=0; in_ovf only -> frac=0, ovf=1, inx=1.
//  in_unf=1, in_man=24'h000000 -> exp=0, frac=0, zero=1, unf=0; in_man=24'h000010 -> unf=1, frac=23'h10.
//  Stream 4 words, out_ready low 3 cycles -> in_ready drops after 2 accepted, no loss/reorder, out_* stable while stalled.
//  Random in_valid/out_ready for 10k words, EXP_W=11 MAN_W=52 -> output sequence equals reference model, in order.
//  FPU_STICKY_FLAGS_EN: ovf result then flag_clr with an inx handshake in the same cycle -> sticky_flags=5'b00001.

Source files
------------

// File: rtl/fp_result_packer.sv
// FP result pack stage: forces special encodings, derives IEEE flags; 1-cycle latency.
// Backpressure: 2-entry skid (output reg + skid reg); in_ready is registered, drops when skid is full.
// Optional FPU_STICKY_FLAGS_EN: accumulates out_flags on each output handshake into sticky_flags.
module fp_result_packer #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [MAN_W:0]   in_man,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_zero,
  input  logic             in_ovf,
  input  logic             in_unf,
  input  logic             in_inv,
  input  logic             in_inx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_frac,
  output logic [4:0]       out_flags,
  input  logic             flag_clr,
  output logic [4:0]       sticky_flags
);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
    logic [4:0]       flags;   // {inv, zero, ovf, unf, inx}
  } res_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;

  buf_state_t       state_q, state_d;
  res_t             packed_w, or_q, or_d, sk_q, sk_d;
  logic [EXP_W-1:0] p_exp;
  logic [MAN_W-1:0] p_frac;
  logic             f_inv, f_zero, f_ovf, f_unf, f_inx;
  logic             push, pop;

  // Hidden bit is implied by the exponent field and is not stored.
  logic unused_hidden;
  assign unused_hidden = in_man[MAN_W];

  always_comb begin
    p_exp  = in_exp;
    p_frac = in_man[MAN_W-1:0];
    if (in_inv) begin
      p_exp  = '1;
      p_frac = '1;
    end else if (in_ovf) begin
      p_exp  = '1;
      p_frac = '0;
    end else if (in_unf) begin
      p_exp  = '0;
    end
    f_inv  = in_inv;
    f_ovf  = in_ovf & ~in_inv;
    f_zero = (in_zero | ((p_exp == '0) && (p_frac == '0))) & ~f_inv & ~f_ovf;
    f_unf  = in_unf & ~f_zero & ~f_inv & ~f_ovf;
    f_inx  = in_inx | f_ovf;
    packed_w = '{sign: in_sign, exp: p_exp, frac: p_frac,
                 flags: {f_inv, f_zero, f_ovf, f_unf, f_inx}};
  end

  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sk_d    = sk_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          or_d    = packed_w;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          or_d = packed_w;
        end else if (push) begin
          sk_d    = packed_w;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (pop) begin
          or_d    = sk_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= EMPTY;
      or_q     <= '0;
      sk_q     <= '0;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      or_q     <= or_d;
      sk_q     <= sk_d;
      in_ready <= (state_d != FULL);
    end
  end

  assign out_sign  = or_q.sign;
  assign out_exp   = or_q.exp;
  assign out_frac  = or_q.frac;
  assign out_flags = or_q.flags;

`ifdef FPU_STICKY_FLAGS_EN
  logic [4:0] sticky_q;

  // A handshake coinciding with a clear lands in the cleared value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sticky_q <= '0;
    end else if (flag_clr) begin
      sticky_q <= pop ? or_q.flags : 5'b00000;
    end else if (pop) begin
      sticky_q <= sticky_q | or_q.flags;
    end
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;
  assign sticky_flags    = 5'b00000;
`endif

endmodule

// File: tb/tb_fp_result_packer.sv
// Bench for fp_result_packer: single-precision directed/stall/sticky/reset cases and a
// double-precision random stream, both scored in order against a reference model.
module tb_fp_result_packer;

  typedef struct packed {
    logic        sign;
    logic [15:0] e;
    logic [63:0] f;
    logic [4:0]  fl;
  } res_t;

`ifdef FPU_STICKY_FLAGS_EN
  localparam logic [4:0] STK_OVF = 5'b00101;
  localparam logic [4:0] STK_INX = 5'b00001;
`else
  localparam logic [4:0] STK_OVF = 5'b00000;
  localparam logic [4:0] STK_INX = 5'b00000;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // single precision instance
  logic        s_in_valid = 0, s_in_ready, s_in_sign = 0;
  logic [23:0] s_in_man = 0;
  logic [7:0]  s_in_exp = 0;
  logic        s_in_zero = 0, s_in_ovf = 0, s_in_unf = 0, s_in_inv = 0, s_in_inx = 0;
  logic        s_out_valid, s_out_ready = 1, s_out_sign;
  logic [7:0]  s_out_exp;
  logic [22:0] s_out_frac;
  logic [4:0]  s_out_flags, s_sticky;
  logic        s_flag_clr = 0;

  // double precision instance
  logic        d_in_valid = 0, d_in_ready, d_in_sign = 0;
  logic [52:0] d_in_man = 0;
  logic [10:0] d_in_exp = 0;
  logic        d_in_zero = 0, d_in_ovf = 0, d_in_unf = 0, d_in_inv = 0, d_in_inx = 0;
  logic        d_out_valid, d_out_ready = 1, d_out_sign;
  logic [10:0] d_out_exp;
  logic [51:0] d_out_frac;
  logic [4:0]  d_out_flags, d_sticky;
  logic        d_flag_clr = 0;

  fp_result_packer #(.EXP_W(8), .MAN_W(23)) dut_s (
    .CLK(CLK), .RST(RST), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_sign(s_in_sign), .in_man(s_in_man), .in_exp(s_in_exp), .in_zero(s_in_zero),
    .in_ovf(s_in_ovf), .in_unf(s_in_unf), .in_inv(s_in_inv), .in_inx(s_in_inx),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sign(s_out_sign),
    .out_exp(s_out_exp), .out_frac(s_out_frac), .out_flags(s_out_flags),
    .flag_clr(s_flag_clr), .sticky_flags(s_sticky));

  fp_result_packer #(.EXP_W(11), .MAN_W(52)) dut_d (
    .CLK(CLK), .RST(RST), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_sign(d_in_sign), .in_man(d_in_man), .in_exp(d_in_exp), .in_zero(d_in_zero),
    .in_ovf(d_in_ovf), .in_unf(d_in_unf), .in_inv(d_in_inv), .in_inx(d_in_inx),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_sign(d_out_sign),
    .out_exp(d_out_exp), .out_frac(d_out_frac), .out_flags(d_out_flags),
    .flag_clr(d_flag_clr), .sticky_flags(d_sticky));

  int   checks = 0;
  int   passed = 0;
  res_t sq[$];
  res_t dq[$];
  bit   rand_done = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: got timeout/unexpected event required normal completion", name);
  endtask

  // Reference: IEEE-style special-case packing written directly from the rules.
  function automatic res_t model(input int ew, input int mw, input logic sg,
                                 input logic [63:0] man, input logic [15:0] e,
                                 input logic z, input logic o, input logic u,
                                 input logic i, input logic x);
    logic [63:0] fmask;
    logic [15:0] emask;
    logic        ovf, zf, unf;
    res_t        r;
    fmask = (64'd1 << mw) - 64'd1;
    emask = (16'd1 << ew) - 16'd1;
    r.sign = sg;
    if (i)      begin r.e = emask; r.f = fmask; end
    else if (o) begin r.e = emask; r.f = 64'd0; end
    else if (u) begin r.e = 16'd0; r.f = man & fmask; end
    else        begin r.e = e & emask; r.f = man & fmask; end
    ovf = o && !i;
    zf  = (z || (r.e == 0 && r.f == 0)) && !i && !ovf;
    unf = u && !zf && !i && !ovf;
    r.fl = {i, zf, ovf, unf, x || ovf};
    return r;
  endfunction

  function automatic res_t mk(input logic sg, input logic [15:0] e, input logic [63:0] f,
                              input logic [4:0] fl);
    res_t r;
    r = '{sign: sg, e: e, f: f, fl: fl};
    return r;
  endfunction

  // fin = {inv, zero, ovf, unf, inx}
  task automatic send_s(input logic sg, input logic [23:0] m, input logic [7:0] e,
                        input logic [4:0] fin, input res_t req);
    bit acc = 0;
    int n = 0;
    s_in_sign = sg; s_in_man = m; s_in_exp = e;
    {s_in_inv, s_in_zero, s_in_ovf, s_in_unf, s_in_inx} = fin;
    s_in_valid = 1;
    while (!acc && n < 100) begin
      @(negedge CLK);
      if (s_in_ready) begin sq.push_back(req); acc = 1; end
      @(posedge CLK); #1;
      n++;
    end
    s_in_valid = 0;
    if (!acc) fail("s_accept_timeout");
  endtask

  task automatic send_d(input logic sg, input logic [63:0] m, input logic [15:0] e,
                        input logic [4:0] fin, input res_t req);
    bit acc = 0;
    int n = 0;
    d_in_sign = sg; d_in_man = m[52:0]; d_in_exp = e[10:0];
    {d_in_inv, d_in_zero, d_in_ovf, d_in_unf, d_in_inx} = fin;
    d_in_valid = 1;
    while (!acc && n < 200) begin
      @(negedge CLK);
      if (d_in_ready) begin dq.push_back(req); acc = 1; end
      @(posedge CLK); #1;
      n++;
    end
    d_in_valid = 0;
    if (!acc) fail("d_accept_timeout");
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sq.size() != 0 || dq.size() != 0) && n < 1000) begin
      @(posedge CLK); #1;
      n++;
    end
    if (sq.size() != 0 || dq.size() != 0) fail("drain_timeout");
  endtask

  function automatic logic [4:0] rand_fin();
    return {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 1) == 1)};
  endfunction

  function automatic logic [63:0] rand_man();
    logic [63:0] m;
    m = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) m = m & 64'hFF;
    if ($urandom_range(0, 7) == 0) m = 64'd0;
    return m;
  endfunction

  // monitors: in-order scoreboard plus stall-stability
  res_t s_prev;
  logic s_prev_stall = 0;
  always @(negedge CLK) begin
    res_t a;
    a = {s_out_sign, 16'(s_out_exp), 64'(s_out_frac), s_out_flags};
    if (RST) s_prev_stall = 0;
    else begin
      if (s_prev_stall) check("s_hold", a, s_prev);
      if (s_out_valid && s_out_ready) begin
        if (sq.size() == 0) fail("s_unexpected_output");
        else check("s_word", a, sq.pop_front());
      end
      s_prev_stall = s_out_valid && !s_out_ready;
      s_prev = a;
    end
  end

  res_t d_prev;
  logic d_prev_stall = 0;
  always @(negedge CLK) begin
    res_t a;
    a = {d_out_sign, 16'(d_out_exp), 64'(d_out_frac), d_out_flags};
    if (RST) d_prev_stall = 0;
    else begin
      if (d_prev_stall) check("d_hold", a, d_prev);
      if (d_out_valid && d_out_ready) begin
        if (dq.size() == 0) fail("d_unexpected_output");
        else check("d_word", a, dq.pop_front());
      end
      d_prev_stall = d_out_valid && !d_out_ready;
      d_prev = a;
    end
  end

  initial begin
    int idx;
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    check("rst_s_out_valid", s_out_valid, 0);
    check("rst_s_in_ready", s_in_ready, 1);
    check("rst_s_out", {s_out_sign, s_out_exp, s_out_frac, s_out_flags}, 0);
    check("rst_s_sticky", s_sticky, 0);
    check("rst_d_out_valid", d_out_valid, 0);
    check("rst_d_in_ready", d_in_ready, 1);
    check("rst_d_out", {d_out_sign, d_out_exp, d_out_frac, d_out_flags}, 0);

    // directed single-precision cases
    send_s(0, 24'h800000, 8'h7F, 5'b00000, mk(0, 16'h7F, 64'h0, 5'b00000));
    send_s(1, 24'h800000, 8'h7F, 5'b10100, mk(1, 16'hFF, 64'h7FFFFF, 5'b10000));
    send_s(0, 24'h800000, 8'h7F, 5'b00100, mk(0, 16'hFF, 64'h0, 5'b00101));
    send_s(0, 24'h000000, 8'h05, 5'b00010, mk(0, 16'h00, 64'h0, 5'b01000));
    send_s(0, 24'h000010, 8'h05, 5'b00010, mk(0, 16'h00, 64'h10, 5'b00010));
    send_s(1, 24'h000000, 8'h00, 5'b01000, mk(1, 16'h00, 64'h0, 5'b01000));
    send_s(0, 24'h000000, 8'h00, 5'b11001, mk(0, 16'hFF, 64'h7FFFFF, 5'b10001));
    wait_drain();

    // 4-word stream against a 3-cycle stall
    s_out_ready = 0;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      s_in_sign = idx[0]; s_in_man = 24'h800000 | 24'(idx + 1); s_in_exp = 8'(8'h10 + idx);
      {s_in_inv, s_in_zero, s_in_ovf, s_in_unf, s_in_inx} = {4'b0000, idx[0]};
      s_in_valid = 1;
      @(negedge CLK);
      if (s_in_ready) begin
        sq.push_back(mk(idx[0], 16'(8'h10 + idx), 64'(idx + 1), {4'b0000, idx[0]}));
        idx++;
      end
      @(posedge CLK); #1;
    end
    check("stall_accepted", idx, 2);
    check("stall_in_ready", s_in_ready, 0);
    s_out_ready = 1;
    for (int c = 0; c < 50 && idx < 4; c++) begin
      s_in_sign = idx[0]; s_in_man = 24'h800000 | 24'(idx + 1); s_in_exp = 8'(8'h10 + idx);
      {s_in_inv, s_in_zero, s_in_ovf, s_in_unf, s_in_inx} = {4'b0000, idx[0]};
      s_in_valid = 1;
      @(negedge CLK);
      if (s_in_ready) begin
        sq.push_back(mk(idx[0], 16'(8'h10 + idx), 64'(idx + 1), {4'b0000, idx[0]}));
        idx++;
      end
      @(posedge CLK); #1;
    end
    s_in_valid = 0;
    check("stream_all_accepted", idx, 4);
    wait_drain();

    // sticky accumulation and clear-with-handshake
    s_flag_clr = 1;
    @(posedge CLK); #1;
    s_flag_clr = 0;
    check("sticky_cleared", s_sticky, 0);
    send_s(0, 24'h800000, 8'h7F, 5'b00100, mk(0, 16'hFF, 64'h0, 5'b00101));
    wait_drain();
    check("sticky_ovf", s_sticky, STK_OVF);
    s_out_ready = 0;
    send_s(0, 24'h800000, 8'h7F, 5'b00001, mk(0, 16'h7F, 64'h0, 5'b00001));
    s_out_ready = 1;
    s_flag_clr = 1;
    @(posedge CLK); #1;
    s_flag_clr = 0;
    check("sticky_clr_same_cycle", s_sticky, STK_INX);
    wait_drain();

    // random single precision, out_ready always high
    for (int n = 0; n < 300; n++) begin
      logic        sg;
      logic [63:0] m;
      logic [15:0] e;
      logic [4:0]  fin;
      sg = 1'($urandom_range(0, 1)); m = rand_man(); e = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) e = 0;
      fin = rand_fin();
      send_s(sg, m[23:0], e[7:0], fin,
             model(8, 23, sg, m, e, fin[3], fin[2], fin[1], fin[4], fin[0]));
    end
    wait_drain();

    // random double precision stream with random backpressure
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          logic        sg;
          logic [63:0] m;
          logic [15:0] e;
          logic [4:0]  fin;
          sg = 1'($urandom_range(0, 1)); m = rand_man(); e = 16'($urandom_range(0, 2047));
          if ($urandom_range(0, 7) == 0) e = 0;
          fin = rand_fin();
          if ($urandom_range(0, 4) == 0) begin @(posedge CLK); #1; end
          send_d(sg, m, e, fin,
                 model(11, 52, sg, m, e, fin[3], fin[2], fin[1], fin[4], fin[0]));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          d_out_ready = ($urandom_range(0, 3) != 0);
          @(posedge CLK); #1;
        end
        d_out_ready = 1;
      end
    join
    wait_drain();

    // reset with a full buffer discards both entries
    s_out_ready = 0;
    send_s(0, 24'h800001, 8'h20, 5'b00000, mk(0, 16'h20, 64'h1, 5'b00000));
    send_s(1, 24'h800002, 8'h21, 5'b00001, mk(1, 16'h21, 64'h2, 5'b00001));
    check("pre_reset_full", s_in_ready, 0);
    RST = 1;
    @(posedge CLK); #1;
    RST = 0;
    sq.delete();
    check("mid_rst_out_valid", s_out_valid, 0);
    check("mid_rst_in_ready", s_in_ready, 1);
    check("mid_rst_out", {s_out_sign, s_out_exp, s_out_frac, s_out_flags}, 0);
    check("mid_rst_sticky", s_sticky, 0);
    s_out_ready = 1;
    repeat (3) @(posedge CLK);
    #1;
    check("post_rst_no_ghost", s_out_valid, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
